// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the register file write port
// between ALU writeback (req 0) and load/link writeback (req 1).
module regfile_write_arbiter #(
  parameter int AW = 5,
  parameter int DW = 32,
  parameter int CW = 16
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          Stall,
  input  logic          Req0,
  input  logic [AW-1:0] Addr0,
  input  logic [DW-1:0] Data0,
  output logic          Gnt0,
  input  logic          Req1,
  input  logic [AW-1:0] Addr1,
  input  logic [DW-1:0] Data1,
  output logic          Gnt1,
  output logic [AW-1:0] W_Addr,
  output logic [DW-1:0] W_Data,
  output logic          Write_Reg,
  output logic [CW-1:0] Cnt0,
  output logic [CW-1:0] Cnt1
);

  logic          last_q, last_d;
  logic [AW-1:0] waddr_q, waddr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          wen_q, wen_d;
  logic [CW-1:0] cnt0_q, cnt0_d;
  logic [CW-1:0] cnt1_q, cnt1_d;
  logic          xfer;
  logic [AW-1:0] win_addr;
  logic [DW-1:0] win_data;

  localparam logic [CW-1:0] CntMax = '1;
  localparam logic [CW-1:0] CntOne = {{(CW-1){1'b0}}, 1'b1};

  // On a tie the requester that did not win last time goes first
  always_comb begin
    Gnt0 = 1'b0;
    Gnt1 = 1'b0;
    if (!Reset && !Stall) begin
      Gnt0 = Req0 & (~Req1 | last_q);
      Gnt1 = Req1 & (~Req0 | ~last_q);
    end
  end

  assign xfer     = Gnt0 | Gnt1;
  assign win_addr = Gnt1 ? Addr1 : Addr0;
  assign win_data = Gnt1 ? Data1 : Data0;

  always_comb begin
    last_d  = last_q;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    wen_d   = 1'b0;
    cnt0_d  = cnt0_q;
    cnt1_d  = cnt1_q;
    if (xfer) begin
      last_d  = Gnt1;
      waddr_d = win_addr;
      wdata_d = win_data;
      wen_d   = (win_addr != '0);
    end
    if (Gnt0 && cnt0_q != CntMax)
      cnt0_d = cnt0_q + CntOne;
    if (Gnt1 && cnt1_q != CntMax)
      cnt1_d = cnt1_q + CntOne;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      last_q  <= 1'b1;
      waddr_q <= '0;
      wdata_q <= '0;
      wen_q   <= 1'b0;
      cnt0_q  <= '0;
      cnt1_q  <= '0;
    end else begin
      last_q  <= last_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      wen_q   <= wen_d;
      cnt0_q  <= cnt0_d;
      cnt1_q  <= cnt1_d;
    end
  end

  assign W_Addr    = waddr_q;
  assign W_Data    = wdata_q;
  assign Write_Reg = wen_q;
  assign Cnt0      = cnt0_q;
  assign Cnt1      = cnt1_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter with a behavioural
// register file capturing the arbiter's write port.
module tb_regfile_write_arbiter;

  logic        Clk = 1'b0;
  logic        Reset, Stall;
  logic        Req0, Req1;
  logic [4:0]  Addr0, Addr1;
  logic [31:0] Data0, Data1;
  logic        Gnt0, Gnt1;
  logic [4:0]  W_Addr;
  logic [31:0] W_Data;
  logic        Write_Reg;
  logic [15:0] Cnt0, Cnt1;

  logic        sGnt0, sGnt1;
  logic [4:0]  sW_Addr;
  logic [31:0] sW_Data;
  logic        sWrite_Reg;
  logic [3:0]  sCnt0, sCnt1;

  logic [31:0] rf [32];

  int nvec = 0;
  int nbad = 0;

  always #5 Clk = ~Clk;

  regfile_write_arbiter dut (
    .Clk(Clk), .Reset(Reset), .Stall(Stall),
    .Req0(Req0), .Addr0(Addr0), .Data0(Data0), .Gnt0(Gnt0),
    .Req1(Req1), .Addr1(Addr1), .Data1(Data1), .Gnt1(Gnt1),
    .W_Addr(W_Addr), .W_Data(W_Data), .Write_Reg(Write_Reg),
    .Cnt0(Cnt0), .Cnt1(Cnt1)
  );

  regfile_write_arbiter #(.CW(4)) dut_s (
    .Clk(Clk), .Reset(Reset), .Stall(Stall),
    .Req0(Req0), .Addr0(Addr0), .Data0(Data0), .Gnt0(sGnt0),
    .Req1(Req1), .Addr1(Addr1), .Data1(Data1), .Gnt1(sGnt1),
    .W_Addr(sW_Addr), .W_Data(sW_Data), .Write_Reg(sWrite_Reg),
    .Cnt0(sCnt0), .Cnt1(sCnt1)
  );

  always @(posedge Clk)
    if (Write_Reg) rf[W_Addr] <= W_Data;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nbad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic edge1();
    @(posedge Clk);
    #1;
  endtask

  task automatic rst_pulse();
    Req0 = 1'b0;
    Req1 = 1'b0;
    Stall = 1'b0;
    Reset = 1'b1;
    #1;
    Reset = 1'b0;
    #1;
  endtask

  initial begin
    Reset = 1'b1; Stall = 1'b0;
    Req0 = 1'b1; Addr0 = 5'd5; Data0 = 32'h1234;
    Req1 = 1'b1; Addr1 = 5'd0; Data1 = 32'h0;
    #2;
    chk("rst_gnt0", 32'(Gnt0), 32'd0);
    chk("rst_gnt1", 32'(Gnt1), 32'd0);
    chk("rst_wen", 32'(Write_Reg), 32'd0);
    chk("rst_waddr", 32'(W_Addr), 32'd0);
    chk("rst_wdata", W_Data, 32'd0);
    chk("rst_cnt0", 32'(Cnt0), 32'd0);
    chk("rst_cnt1", 32'(Cnt1), 32'd0);
    Req1 = 1'b0;
    edge1();
    Reset = 1'b0;
    #1;
    // single request from requester 0
    chk("t1_gnt0", 32'(Gnt0), 32'd1);
    chk("t1_gnt1", 32'(Gnt1), 32'd0);
    edge1();
    Req0 = 1'b0;
    chk("t1_wen", 32'(Write_Reg), 32'd1);
    chk("t1_waddr", 32'(W_Addr), 32'd5);
    chk("t1_wdata", W_Data, 32'h1234);
    chk("t1_cnt0", 32'(Cnt0), 32'd1);

    // both held: alternate 0,1,0,1 from a fresh reset
    rst_pulse();
    Req0 = 1'b1; Addr0 = 5'd3; Data0 = 32'hA;
    Req1 = 1'b1; Addr1 = 5'd4; Data1 = 32'hB;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("t2_gnt0", 32'(Gnt0), (i % 2 == 0) ? 32'd1 : 32'd0);
      chk("t2_gnt1", 32'(Gnt1), (i % 2 == 0) ? 32'd0 : 32'd1);
      edge1();
      chk("t2_wen", 32'(Write_Reg), 32'd1);
      chk("t2_waddr", 32'(W_Addr), (i % 2 == 0) ? 32'd3 : 32'd4);
      chk("t2_wdata", W_Data, (i % 2 == 0) ? 32'hA : 32'hB);
    end
    Req0 = 1'b0; Req1 = 1'b0;
    chk("t2_cnt0", 32'(Cnt0), 32'd2);
    chk("t2_cnt1", 32'(Cnt1), 32'd2);
    edge1();
    chk("t2_idle_wen", 32'(Write_Reg), 32'd0);
    chk("t2_idle_waddr", 32'(W_Addr), 32'd4);

    // write to register 0 counts but never enables
    Req1 = 1'b1; Addr1 = 5'd0; Data1 = 32'hFFFF_FFFF;
    #1;
    chk("t3_gnt1", 32'(Gnt1), 32'd1);
    edge1();
    Req1 = 1'b0;
    chk("t3_wen", 32'(Write_Reg), 32'd0);
    chk("t3_cnt1", 32'(Cnt1), 32'd3);
    chk("t3_cnt0", 32'(Cnt0), 32'd2);

    // stall with both requesting, same destination
    Req0 = 1'b1; Addr0 = 5'd7; Data0 = 32'h11;
    Req1 = 1'b1; Addr1 = 5'd7; Data1 = 32'h22;
    Stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t4_stall_gnt0", 32'(Gnt0), 32'd0);
      chk("t4_stall_gnt1", 32'(Gnt1), 32'd0);
      edge1();
      chk("t4_stall_wen", 32'(Write_Reg), 32'd0);
      chk("t4_stall_cnt1", 32'(Cnt1), 32'd3);
    end
    Stall = 1'b0;
    #1;
    chk("t5_gnt0", 32'(Gnt0), 32'd1);
    chk("t5_gnt1", 32'(Gnt1), 32'd0);
    edge1();
    Req0 = 1'b0;
    chk("t5_wen_a", 32'(Write_Reg), 32'd1);
    chk("t5_wdata_a", W_Data, 32'h11);
    #1;
    chk("t5_gnt1_b", 32'(Gnt1), 32'd1);
    edge1();
    Req1 = 1'b0;
    chk("t5_wen_b", 32'(Write_Reg), 32'd1);
    chk("t5_wdata_b", W_Data, 32'h22);
    chk("t5_rf7_mid", rf[7], 32'h11);
    edge1();
    chk("t5_rf7_final", rf[7], 32'h22);
    chk("t5_wen_off", 32'(Write_Reg), 32'd0);
    chk("t5_cnt0", 32'(Cnt0), 32'd3);
    chk("t5_cnt1", 32'(Cnt1), 32'd4);

    // saturation on the 4-bit instance, then reset mid-write
    rst_pulse();
    chk("t6_cnt0_clr", 32'(Cnt0), 32'd0);
    Req0 = 1'b1; Addr0 = 5'd9;
    for (int i = 0; i < 20; i++) begin
      Data0 = (i == 19) ? 32'hBEEF : 32'h5;
      edge1();
      if (i == 14) chk("t6_scnt_15", 32'(sCnt0), 32'd15);
    end
    Req0 = 1'b0;
    chk("t6_scnt_sat", 32'(sCnt0), 32'd15);
    chk("t6_cnt0_20", 32'(Cnt0), 32'd20);
    chk("t6_wen", 32'(Write_Reg), 32'd1);
    chk("t6_wdata", W_Data, 32'hBEEF);
    Reset = 1'b1;
    #1;
    chk("t7_wen", 32'(Write_Reg), 32'd0);
    chk("t7_cnt0", 32'(Cnt0), 32'd0);
    chk("t7_scnt0", 32'(sCnt0), 32'd0);
    chk("t7_waddr", 32'(W_Addr), 32'd0);
    edge1();
    chk("t7_rf9", rf[9], 32'h5);
    Reset = 1'b0;
    Req0 = 1'b1; Req1 = 1'b1;
    #1;
    chk("t7_tie_gnt0", 32'(Gnt0), 32'd1);
    chk("t7_tie_gnt1", 32'(Gnt1), 32'd0);
    Req0 = 1'b0; Req1 = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Shares the single write port of the 32x32 register file between two writeback sources.
  - Requester 0: ALU/R-type writeback.
  - Requester 1: load/link writeback.
- Sits between the writeback stage and the register file. Drives the file's write address, write data and write-enable from registered outputs.
- Round-robin arbitration, valid/grant handshake, stall input, and per-requester saturating grant counters for debug.

Parameters:
AW, 5, register address width
DW, 32, write data width
CW, 16, grant counter width

Ports:
Clk  input  1  clock, rising edge
Reset  input  1  reset, asynchronous, active-high
Stall  input  1  high = no grants issued this cycle
Req0  input  1  requester 0 write request
Addr0  input  AW  requester 0 destination register
Data0  input  DW  requester 0 write data
Gnt0  output  1  requester 0 accepted this cycle (combinational)
Req1  input  1  requester 1 write request
Addr1  input  AW  requester 1 destination register
Data1  input  DW  requester 1 write data
Gnt1  output  1  requester 1 accepted this cycle (combinational)
W_Addr  output  AW  to register file write address (registered)
W_Data  output  DW  to register file write data (registered)
Write_Reg  output  1  to register file write enable (registered)
Cnt0  output  CW  saturating count of Req0 grants
Cnt1  output  CW  saturating count of Req1 grants

Behaviour:
- Reset (async, immediate):
  - Write_Reg=0, W_Addr=0, W_Data=0, Cnt0=0, Cnt1=0.
  - Priority pointer Last=1, so requester 0 wins the first tie.
  - Gnt0/Gnt1 are forced 0 while Reset is high.
- Handshake:
  - ReqN must hold with stable AddrN/DataN until GntN=1.
  - A transfer occurs in any cycle with ReqN&GntN.
  - GntN is combinational from Req0, Req1, Stall and Last. It never asserts without ReqN.
- Arbitration (per cycle, Stall=0):
  - Only Req0: Gnt0=1.
  - Only Req1: Gnt1=1.
  - Both: the requester not equal to Last wins. The loser holds its request and wins the next cycle if still requesting.
  - At most one grant per cycle.
  - Last updates to the winner's index at the clock edge of a transfer. It is unchanged when there is no grant.
- Stall=1: Gnt0=Gnt1=0. Last and counters are frozen. Output registers still update as described under "Output timing".
- Output timing, latency 1:
  - At the edge ending a transfer cycle: W_Addr/W_Data <= winner's Addr/Data; Write_Reg <= (winner Addr != 0).
  - A transfer to register 0 completes the handshake and counts, but never asserts Write_Reg.
  - At an edge with no transfer: Write_Reg <= 0; W_Addr/W_Data hold their previous values.
  - The register file captures on the edge following the Write_Reg=1 cycle. Total request-to-write latency is 2 edges.
- Back-to-back: sustained grants give Write_Reg=1 every cycle, with one write per cycle.
- Same-address conflict: both requesters target the same register in one cycle. They are serialised in round-robin order, so the later grant's data is the final register value. No merging or dropping.
- Counters: CntN increments on each GntN transfer and saturates at 2^CW-1 (no wrap).
- Reset mid-operation:
  - An in-flight registered write is cancelled (Write_Reg cleared immediately).
  - Pending requests are not remembered. Requesters re-request after Reset deasserts.
- No ready/full state beyond the output register. The arbiter never back-pressures except by withholding grant.

Test Plan:
- Reset then Req0=1, Addr0=5, Data0=0x1234 for one cycle -> Gnt0=1 in the same cycle; next cycle Write_Reg=1, W_Addr=5, W_Data=0x1234; Cnt0=1.
- Req0 and Req1 both held 4 cycles (Addr 3/4, Data 0xA/0xB) -> grants alternate 0,1,0,1; Write_Reg=1 for 4 consecutive cycles starting one cycle later; Cnt0=2, Cnt1=2.
- Req1=1 with Addr1=0, Data1=0xFFFF_FFFF -> Gnt1=1; next cycle Write_Reg=0; Cnt1 increments.
- Both requesting, Stall=1 for 3 cycles then 0 -> no grants and Write_Reg=0 during the stall; after the stall the requester not equal to Last is granted first.
- Both target Addr=7 (Data0=0x11, Data1=0x22) with Last=1 -> req0 writes first, then req1; register 7 ends at 0x22.
- Set CW=4 and grant Req0 20 times -> Cnt0 stops at 15. Assert Reset during a Write_Reg=1 cycle -> Write_Reg=0 immediately, counters 0, no write reaches the register file.
